// File: rtl/fetch_pkg.sv
// Shared constants for the instruction prefetch unit.
// Defaults for width, reset PC and the NOP filler word.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Head word is presented combinationally from the read pointer.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full queue still accepts a write when the head leaves in the same edge
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instruction_prefetch.sv
// Credit-limited instruction prefetch queue with redirect and drop.
// FETCH_MISALIGN_CHECK_EN adds fetch_misaligned and halts on odd targets.
module instruction_prefetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            fetch_misaligned,
`endif
    output logic            valid_out,
    output logic [XLEN-1:0] Instruction,
    output logic [XLEN-1:0] pc_out
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   target;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     tag_count;
    logic [CW-1:0]     q_count;
    logic [CW:0]       credit;
    logic              halted;
    logic              push;
    logic              pop;
    logic [XLEN-1:0]   rsp_pc;
    logic [2*XLEN-1:0] head;

    assign target = {branch_target[XLEN-1:2], 2'b00};
    assign credit = {1'b0, q_count} + {1'b0, tag_count};

    assign imem_req  = rst && !pc_src && !halted && (credit < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign push = imem_rvalid && (drop_cnt == '0) && !pc_src && !halted;
    assign pop  = valid_out && !stall && !pc_src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (pc_src) begin
            fetch_pc <= target;
            // Every tag still in flight after this edge belongs to the old path
            drop_cnt <= tag_count - CW'(imem_rvalid);
        end else begin
            if (imem_req) fetch_pc <= fetch_pc + XLEN'(4);
            if (imem_rvalid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        halted <= 1'b0;
        else if (pc_src) halted <= (branch_target[1:0] != 2'b00);
    end
    assign fetch_misaligned = halted;
`else
    logic unused_low;
    assign halted     = 1'b0;
    assign unused_low = ^branch_target[1:0];
`endif

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (imem_req),
        .wdata (fetch_pc),
        .pop   (imem_rvalid),
        .rdata (rsp_pc),
        .count (tag_count)
    );

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (pc_src),
        .push  (push),
        .wdata ({rsp_pc, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (q_count)
    );

    assign valid_out   = (q_count != '0);
    assign Instruction = valid_out ? head[XLEN-1:0] : XLEN'(NOP);
    assign pc_out      = valid_out ? head[2*XLEN-1:XLEN] : RESET_PC;

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch with a 2-cycle memory.
// Define FETCH_MISALIGN_CHECK_EN to exercise the misalign halt.
module tb_instruction_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] Instruction;
    logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_prefetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .valid_out     (valid_out),
        .Instruction   (Instruction),
        .pc_out        (pc_out)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    logic        v0, v1;
    logic [31:0] a0, a1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            a0 <= '0;
            a1 <= '0;
        end else begin
            v0 <= imem_req;
            a0 <= imem_addr;
            v1 <= v0;
            a1 <= a0;
        end
    end

    assign imem_rvalid = v1;
    assign imem_rdata  = word(a1);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!valid_out && n < 20) begin
            step();
            n++;
        end
        if (!valid_out) check({tag, "_timeout"}, 32'(valid_out), 32'd1);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(valid_out), 32'd1);
        check({tag, "_pc"}, pc_out, pc);
        check({tag, "_instr"}, Instruction, word(pc));
    endtask

    int n;
    int reqs;

    initial begin
        rst           = 1'b1;
        pc_src        = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_instr", Instruction, 32'h0000_0013);
        check("rst_pc", pc_out, 32'h0);
        check("rst_req", 32'(imem_req), 32'd0);

        // reset release and basic stream
        step();
        rst = 1'b1;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        wait_valid("lat", n);
        check("latency", 32'(n), 32'd3);
        for (int i = 0; i < 4; i++) begin
            check_head("seq", 32'(i * 4));
            step();
        end

        // stall from release: credit stops at DEPTH
        stall = 1'b1;
        do_reset();
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) reqs++;
            step();
        end
        check("stall_reqs", 32'(reqs), 32'd4);
        check("stall_req_now", 32'(imem_req), 32'd0);
        check_head("stall_hold", 32'h0);
        step();
        check_head("stall_hold2", 32'h0);
        stall = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_head("resume", 32'(i * 4));
            step();
        end

        // redirect with two requests outstanding
        do_reset();
        step();
        step();
        pc_src        = 1'b1;
        branch_target = 32'h80;
        #1;
        check("redir_req", 32'(imem_req), 32'd0);
        step();
        pc_src = 1'b0;
        #1;
        check("redir_valid", 32'(valid_out), 32'd0);
        check("redir_req1", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h80);
        wait_valid("redir", n);
        check_head("redir0", 32'h80);
        step();
        check_head("redir1", 32'h84);

        // redirect and stall together
        stall         = 1'b1;
        pc_src        = 1'b1;
        branch_target = 32'h200;
        step();
        pc_src = 1'b0;
        stall  = 1'b0;
        #1;
        check("ps_valid", 32'(valid_out), 32'd0);
        check("ps_addr", imem_addr, 32'h200);
        wait_valid("ps", n);
        check_head("ps0", 32'h200);

        // back-to-back redirects: last wins
        pc_src        = 1'b1;
        branch_target = 32'h300;
        step();
        branch_target = 32'h400;
        step();
        pc_src = 1'b0;
        #1;
        check("b2b_addr", imem_addr, 32'h400);
        wait_valid("b2b", n);
        check_head("b2b0", 32'h400);
        step();
        check_head("b2b1", 32'h404);

        // fetch_pc wraps at the top of the address space
        pc_src        = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        pc_src = 1'b0;
        #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_req1", 32'(imem_req), 32'd1);
        check("wrap_addr1", imem_addr, 32'h0);
        wait_valid("wrap", n);
        check_head("wrap0", 32'hFFFF_FFFC);
        step();
        check_head("wrap1", 32'h0);

        // asynchronous reset while the queue is populated
        stall = 1'b1;
        repeat (5) step();
        check("mid_qd", 32'(valid_out), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_valid", 32'(valid_out), 32'd0);
        check("mid_instr", Instruction, 32'h0000_0013);
        check("mid_pc", pc_out, 32'h0);
        check("mid_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mid_addr", imem_addr, 32'h0);
        check("mid_req1", 32'(imem_req), 32'd1);
        wait_valid("mid", n);
        check_head("mid0", 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_rst", 32'(fetch_misaligned), 32'd0);
        pc_src        = 1'b1;
        branch_target = 32'h83;
        step();
        pc_src = 1'b0;
        #1;
        check("mis_flag", 32'(fetch_misaligned), 32'd1);
        check("mis_req", 32'(imem_req), 32'd0);
        repeat (4) step();
        check("mis_req_hold", 32'(imem_req), 32'd0);
        check("mis_valid", 32'(valid_out), 32'd0);
        pc_src        = 1'b1;
        branch_target = 32'h100;
        step();
        pc_src = 1'b0;
        #1;
        check("mis_clr", 32'(fetch_misaligned), 32'd0);
        check("mis_req1", 32'(imem_req), 32'd1);
        check("mis_addr", imem_addr, 32'h100);
        wait_valid("mis", n);
        check_head("mis0", 32'h100);
`else
        pc_src        = 1'b1;
        branch_target = 32'h83;
        step();
        pc_src = 1'b0;
        #1;
        check("align_req", 32'(imem_req), 32'd1);
        check("align_addr", imem_addr, 32'h80);
        wait_valid("align", n);
        check_head("align0", 32'h80);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch.md
INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 Parameter XLEN, default 32, instruction and address width.
REQ-002 Parameter DEPTH, default 4, power of two >= 2, queue entries and maximum outstanding requests combined.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 pc_src  input  1  redirect strobe; 1 = fetch from branch_target.
REQ-007 branch_target  input  XLEN  redirect address.
REQ-008 stall  input  1  consumer hold; 1 = head not consumed this cycle.
REQ-009 imem_req  output  1  fetch request valid; accepted in the same cycle, no back-pressure.
REQ-010 imem_addr  output  XLEN  fetch address, word aligned.
REQ-011 imem_rvalid  input  1  response valid; responses arrive in request order, latency >= 1 cycle.
REQ-012 imem_rdata  input  XLEN  response instruction word.
REQ-013 valid_out  output  1  Instruction and pc_out hold a live instruction.
REQ-014 Instruction  output  XLEN  head instruction; NOP 32'h0000_0013 when valid_out = 0.
REQ-015 pc_out  output  XLEN  address of the head instruction.

Function
REQ-016 Shall keep fetch_pc, the next request address, advanced by 4 on each issued request.
REQ-017 Shall assert imem_req only when queue_count + outstanding < DEPTH, pc_src = 0 and the block is not halted.
REQ-018 Shall push each non-dropped response, with its PC from an in-order PC tag queue, into the instruction queue in the rvalid cycle.
REQ-019 Head becomes visible on valid_out one cycle after the push: minimum latency from imem_req to valid_out is memory latency + 1.
REQ-020 Shall pop the head on the rising edge when valid_out = 1 and stall = 0; simultaneous push and pop at full occupancy shall be lossless.
REQ-021 While stall = 1, Instruction, pc_out and valid_out shall remain unchanged; fetching continues until credit is exhausted.
REQ-022 On pc_src = 1, the next edge shall empty the queue, set fetch_pc = branch_target and load drop_cnt = outstanding, less any response arriving in that same cycle.
REQ-023 While drop_cnt > 0, each imem_rvalid shall decrement drop_cnt and its data shall be discarded.
REQ-024 The first request to branch_target shall issue in the cycle after pc_src; valid_out shall be 0 in that cycle.
REQ-025 pc_src shall take priority over stall, pop and push in the same cycle.
REQ-026 Back-to-back pc_src cycles: the last one wins; drop_cnt shall accumulate correctly.
REQ-027 Queue pointers shall wrap modulo DEPTH; fetch_pc shall wrap modulo 2^XLEN.

Reset
REQ-028 rst = 0 shall, asynchronously, clear queue, outstanding and drop_cnt, and set fetch_pc = RESET_PC, imem_req = 0, valid_out = 0, Instruction = NOP and pc_out = RESET_PC.
REQ-029 The first imem_req shall assert in the first clock cycle after rst deasserts; responses in flight at reset shall be ignored by the memory model.

Configuration
REQ-030 With FETCH_MISALIGN_CHECK_EN defined: output fetch_misaligned (1 bit) shall set when pc_src = 1 and branch_target[1:0] != 0. The block then halts, with no requests and the queue emptied, until the next aligned pc_src, which clears the flag. Reset clears it.
REQ-031 Without FETCH_MISALIGN_CHECK_EN: no port; branch_target[1:0] shall be forced to 0.

Structure
REQ-032 Package fetch_pkg shall hold XLEN default, the NOP constant and RESET_PC default.
REQ-033 Sub-module fetch_fifo (parametrised width/depth, sync, count output) shall be instantiated twice: PC tag queue and instruction queue.

Verification
REQ-034 Reset release, 2-cycle memory returning addr-based words, stall = 0: pc_out sequence 0, 4, 8, 12; first valid_out 3 cycles after the first imem_req.
REQ-035 stall = 1 for 6 cycles, DEPTH = 4: at most 4 requests outstanding or queued; head held at pc_out = 0; resumes in order on release.
REQ-036 pc_src = 1, branch_target = 32'h80 with 2 outstanding: both stale responses dropped; next valid pc_out = 32'h80, then 32'h84.
REQ-037 pc_src and stall both 1 in the same cycle: redirect taken; valid_out = 0 next cycle.
REQ-038 rst asserted mid-stream with 3 entries queued: valid_out = 0 immediately; first request after release at RESET_PC.
REQ-039 With FETCH_MISALIGN_CHECK_EN: branch_target = 32'h83 -> fetch_misaligned = 1, imem_req = 0; aligned redirect to 32'h100 clears the flag and fetches 32'h100.
